hazard_scoreboard: RTL

- Consumer end of the decoded control word. Sits in the ID stage of the 5-stage LC-3b pipeline.
- Takes the per-instruction source, destination and branch flags produced by the decoder, plus writeback and branch-resolution events from later stages.
- Tracks in-flight register writes per architectural register and holds the decoded instruction in ID until its operands are safe.
- Blocks issue behind an unresolved control transfer and pulses a fetch flush on a taken branch.

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 49 ++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode, writeback and branch events in; issue/stall/flush/error out.
// master drives the events and reads the results; slave is the scoreboard side.
interface hazard_scoreboard_if;
  logic       id_valid;
  logic       id_uses_sr1;
  logic       id_uses_sr2;
  logic       id_write_memory;
  logic       id_load_regfile;
  logic       id_branch;
  logic [2:0] id_sr1;
  logic [2:0] id_sr2;
  logic [2:0] id_dest;
  logic       ext_stall;
  logic       wb_retire;
  logic [2:0] wb_dest;
  logic       br_resolve;
  logic       br_taken;
  logic       issue;
  logic       stall_id;
  logic       flush_if;
  logic       sb_err;
  modport master (
    output id_valid, id_uses_sr1, id_uses_sr2, id_write_memory, id_load_regfile, id_branch,
           id_sr1, id_sr2, id_dest, ext_stall, wb_retire, wb_dest, br_resolve, br_taken,
    input  issue, stall_id, flush_if, sb_err
  );
  modport slave (
    input  id_valid, id_uses_sr1, id_uses_sr2, id_write_memory, id_load_regfile, id_branch,
           id_sr1, id_sr2, id_dest, ext_stall, wb_retire, wb_dest, br_resolve, br_taken,
    output issue, stall_id, flush_if, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage RAW/WAW/control-transfer hazard scoreboard for the LC-3b pipeline.
// clk/reset_n: clock and async active-low reset; sb: decode/writeback/branch events in,
// issue and stall_id (combinational), flush_if (registered pulse), sb_err (sticky) out.
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int NUM_REGS     = 8
) (
  input  logic clk,
  input  logic reset_n,
  hazard_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0][1:0] pend_cnt_q, pend_cnt_d;
  logic br_pending_q, br_pending_d, flush_q, flush_d, sb_err_q, sb_err_d;
  logic raw_hazard, waw_full, block;
  always_comb begin
    raw_hazard = (sb.id_uses_sr1 && pend_cnt_q[sb.id_sr1] != 2'd0) ||
                 ((sb.id_uses_sr2 || sb.id_write_memory) && pend_cnt_q[sb.id_sr2] != 2'd0);
    waw_full   = sb.id_load_regfile && pend_cnt_q[sb.id_dest] == 2'(MAX_INFLIGHT);
    block      = raw_hazard || waw_full || br_pending_q || sb.ext_stall;
  end
  assign sb.issue    = reset_n && sb.id_valid && !block;
  assign sb.stall_id = !reset_n || (sb.id_valid && block);
  assign sb.flush_if = flush_q;
  assign sb.sb_err   = sb_err_q;
  // A retire against an empty counter is an error, never an underflow.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    for (int r = 0; r < NUM_REGS; r++)
      pend_cnt_d[r] = pend_cnt_q[r]
                    + {1'b0, sb.issue && sb.id_load_regfile && sb.id_dest == 3'(r)}
                    - {1'b0, sb.wb_retire && sb.wb_dest == 3'(r) && pend_cnt_q[r] != 2'd0};
    sb_err_d     = sb_err_q || (sb.wb_retire && pend_cnt_q[sb.wb_dest] == 2'd0);
    br_pending_d = (sb.issue && sb.id_branch) || (br_pending_q && !sb.br_resolve);
    flush_d      = sb.br_resolve && sb.br_taken && br_pending_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_cnt_q   <= '0;
      br_pending_q <= 1'b0;
      flush_q      <= 1'b0;
      sb_err_q     <= 1'b0;
    end else begin
      pend_cnt_q   <= pend_cnt_d;
      br_pending_q <= br_pending_d;
      flush_q      <= flush_d;
      sb_err_q     <= sb_err_d;
    end
  end
endmodule
